// File: rtl/l2_victim_buffer.sv
// Write-back victim buffer between the L2 pmem port and physical memory.
// Evictions are queued in a small FIFO, refills bypass them, read hits forward from the buffer.
module l2_victim_buffer #(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 16,
  parameter int LINE_W   = 128,
  parameter int OFFSET_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          mem_address,
  input  logic [LINE_W-1:0]          mem_wdata,
  input  logic                       mem_read,
  input  logic                       mem_write,
  output logic [LINE_W-1:0]          mem_rdata,
  output logic                       mem_resp,
  output logic [ADDR_W-1:0]          pmem_address,
  output logic [LINE_W-1:0]          pmem_wdata,
  output logic                       pmem_read,
  output logic                       pmem_write,
  input  logic [LINE_W-1:0]          pmem_rdata,
  input  logic                       pmem_resp,
  output logic [$clog2(DEPTH+1)-1:0] buf_count
);

  localparam int TAG_W = ADDR_W - OFFSET_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_PMEM = 2'd1,
    DRAIN     = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t            state_r;
  logic              valid_r [DEPTH];
  logic [TAG_W-1:0]  tag_r   [DEPTH];
  logic [LINE_W-1:0] line_r  [DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;

  logic [TAG_W-1:0]  req_tag_s;
  logic              hit_s;
  logic [PTR_W-1:0]  hit_idx_s;
  logic              full_s;
  logic              unused_offset_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign req_tag_s       = mem_address[ADDR_W-1:OFFSET_W];
  assign unused_offset_s = ^mem_address[OFFSET_W-1:0];
  assign full_s          = (count_r == CNT_W'(DEPTH));
  assign buf_count       = count_r;

  // Tag lookup across valid entries; coalescing keeps at most one match.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = {PTR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      hit_idx_s = (valid_r[i] && (tag_r[i] == req_tag_s)) ? PTR_W'(i) : hit_idx_s;
      hit_s     = hit_s | (valid_r[i] && (tag_r[i] == req_tag_s));
    end
  end

  // Control FSM, FIFO storage and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      head_r       <= {PTR_W{1'b0}};
      tail_r       <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      mem_resp     <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      mem_rdata    <= {LINE_W{1'b0}};
      pmem_address <= {ADDR_W{1'b0}};
      pmem_wdata   <= {LINE_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i] <= 1'b0;
        tag_r[i]   <= {TAG_W{1'b0}};
        line_r[i]  <= {LINE_W{1'b0}};
      end
    end else begin
      case (state_r)
        IDLE: begin
          mem_resp <= 1'b0;
          if (mem_read) begin
            if (hit_s) begin
              mem_rdata <= line_r[hit_idx_s];
              state_r   <= RESP;
            end else begin
              pmem_read    <= 1'b1;
              pmem_address <= {req_tag_s, {OFFSET_W{1'b0}}};
              state_r      <= READ_PMEM;
            end
          end else if (mem_write && hit_s) begin
            line_r[hit_idx_s] <= mem_wdata;
            state_r           <= RESP;
          end else if (mem_write && !full_s) begin
            valid_r[tail_r] <= 1'b1;
            tag_r[tail_r]   <= req_tag_s;
            line_r[tail_r]  <= mem_wdata;
            tail_r          <= ptr_inc(tail_r);
            count_r         <= count_r + CNT_W'(1);
            state_r         <= RESP;
          end else if (count_r != {CNT_W{1'b0}}) begin
            // Idle drain, or a forced drain when a write misses on a full buffer.
            pmem_write   <= 1'b1;
            pmem_address <= {tag_r[head_r], {OFFSET_W{1'b0}}};
            pmem_wdata   <= line_r[head_r];
            state_r      <= DRAIN;
          end else begin
            state_r <= IDLE;
          end
        end
        READ_PMEM: begin
          if (pmem_resp) begin
            mem_rdata <= pmem_rdata;
            pmem_read <= 1'b0;
            state_r   <= RESP;
          end else begin
            state_r <= READ_PMEM;
          end
        end
        DRAIN: begin
          if (pmem_resp) begin
            pmem_write      <= 1'b0;
            valid_r[head_r] <= 1'b0;
            head_r          <= ptr_inc(head_r);
            count_r         <= count_r - CNT_W'(1);
            state_r         <= IDLE;
          end else begin
            state_r <= DRAIN;
          end
        end
        RESP: begin
          mem_resp <= 1'b1;
          state_r  <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
